// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction/data) arbiter and sequencer for a single memory port, with a watchdog abort.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise the data side always wins ties.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_DataIn,
    output logic        mem_RW,
    output logic        mem_valid,
    input  logic        mem_done,
    input  logic [31:0] mem_DataR
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        owner_d;
    logic [7:0]  wd_cnt;
    logic        pick_d;
    logic        finish;
    logic [31:0] rsp_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // On a tie the side not served last wins.
    always_comb begin
        pick_d = d_req;
        if (i_req && d_req)
            pick_d = !last_d;
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    always_comb begin
        finish   = mem_done || (wd_cnt == WD_LAST);
        rsp_data = (mem_done && !mem_RW) ? mem_DataR : 32'h0;
        state_nx = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nx = BUSY;
            BUSY:    if (finish) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            wd_cnt      <= 8'h0;
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            i_rvalid    <= 1'b0;
            d_rvalid    <= 1'b0;
            i_rdata     <= 32'h0;
            d_rdata     <= 32'h0;
            err         <= 1'b0;
            mem_address <= 32'h0;
            mem_DataIn  <= 32'h0;
            mem_RW      <= 1'b0;
            mem_valid   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b1;
`endif
        end else begin
            state    <= state_nx;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d     <= pick_d;
                        i_gnt       <= !pick_d;
                        d_gnt       <= pick_d;
                        mem_valid   <= 1'b1;
                        wd_cnt      <= 8'h0;
                        mem_address <= pick_d ? d_addr : i_addr;
                        mem_DataIn  <= pick_d ? d_wdata : 32'h0;
                        mem_RW      <= pick_d & d_rw;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d      <= pick_d;
`endif
                    end
                end
                BUSY: begin
                    if (finish) begin
                        // Completion wins over a watchdog expiry in the same cycle.
                        mem_valid <= 1'b0;
                        err       <= !mem_done;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= rsp_data;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= rsp_data;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses, a negedge monitor pops and checks them.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, mem_done = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_DataR = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, err, mem_RW, mem_valid;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_DataIn;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
        .mem_address(mem_address), .mem_DataIn(mem_DataIn), .mem_RW(mem_RW),
        .mem_valid(mem_valid), .mem_done(mem_done), .mem_DataR(mem_DataR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        int          at;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0, errors = 0;
    logic prev_mv = 1'b0;
    logic [31:0] mon_data;

    wire [134:0] outs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, err,
                         mem_address, mem_DataIn, mem_RW, mem_valid};

    // Monitor: every rvalid must match the head of the scoreboard, every grant must open a fresh access.
    always @(negedge clk) begin
        if (i_rvalid || d_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: i_rvalid=%0b d_rvalid=%0b at cyc %0d, required none",
                         i_rvalid, d_rvalid, cyc);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_data = d_rvalid ? d_rdata : i_rdata;
                if ((i_rvalid && d_rvalid) || d_rvalid !== mon_e.is_d || mon_data !== mon_e.data ||
                    err !== mon_e.err || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL response: got d=%0b data=%h err=%0b cyc=%0d, required d=%0b data=%h err=%0b cyc=%0d",
                             d_rvalid, mon_data, err, cyc, mon_e.is_d, mon_e.data, mon_e.err, mon_e.at);
                end
            end
        end
        if (i_gnt || d_gnt) begin
            checks++;
            if ((i_gnt && d_gnt) || !mem_valid || prev_mv) begin
                errors++;
                $display("FAIL grant_overlap: i_gnt=%0b d_gnt=%0b mem_valid=%0b prev_mem_valid=%0b, required single gnt opening a new access",
                         i_gnt, d_gnt, mem_valid, prev_mv);
            end
        end
        prev_mv = mem_valid;
    end

    // One request from a single side; done in BUSY cycle k (k=0: never, watchdog abort).
    task automatic access(input logic is_d, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mdata, input int k,
                          input string name);
        int   r, g;
        logic seen;
        rsp_t e;
        @(posedge clk); #1;
        r = cyc;
        if (is_d) begin
            d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = is_d ? d_gnt : i_gnt;
        end
        checks++;
        if (!seen || cyc != r + 1) begin
            errors++;
            $display("FAIL %s_gnt: seen=%0b at cyc %0d, required grant at cyc %0d", name, seen, cyc, r + 1);
            i_req = 1'b0; d_req = 1'b0;
            return;
        end
        g = cyc;
        i_req = 1'b0; d_req = 1'b0;
        e.is_d = is_d;
        e.data = (k == 0 || (is_d && rw)) ? 32'h0 : mdata;
        e.err  = (k == 0);
        e.at   = g + ((k == 0) ? TO : k);
        exp_q.push_back(e);
        mem_DataR = mdata;
        for (int j = 1; j <= TO; j++) begin
            mem_done = (j == k);
            checks++;
            if (mem_valid !== 1'b1 || mem_address !== addr || mem_RW !== (is_d & rw) ||
                (is_d && mem_DataIn !== wdata)) begin
                errors++;
                $display("FAIL %s_busy%0d: valid=%0b addr=%h din=%h rw=%0b, required valid=1 addr=%h din=%h rw=%0b",
                         name, j, mem_valid, mem_address, mem_DataIn, mem_RW, addr, wdata, is_d & rw);
            end
            if (j == k) break;
            @(negedge clk);
        end
        @(negedge clk);
        mem_done = 1'b0;
    endtask

    logic ord [0:3];
    logic seen;
    rsp_t te;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(posedge clk); #1 rst = 1'b0;

        // Tie: both sides request continuously, memory completes immediately.
        mem_done = 1'b1; mem_DataR = 32'hA5A5_0001;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h300;
        for (int n = 0; n < 4; n++) begin
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                seen = i_gnt || d_gnt;
            end
            checks++;
            if (!seen || d_gnt !== ord[n]) begin
                errors++;
                $display("FAIL tie_order%0d: seen=%0b d_gnt=%0b, required d_gnt=%0b", n, seen, d_gnt, ord[n]);
            end
            if (seen) begin
                te.is_d = d_gnt; te.data = 32'hA5A5_0001; te.err = 1'b0; te.at = cyc + 1;
                exp_q.push_back(te);
            end
        end
        d_req = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = i_gnt;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tie_i_after_d: no i_gnt, required i_gnt once d_req drops");
        end else begin
            te.is_d = 1'b0; te.data = 32'hA5A5_0001; te.err = 1'b0; te.at = cyc + 1;
            exp_q.push_back(te);
        end
`endif
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        mem_done = 1'b1;

        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, "single_read");
        access(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_0000, 4, "data_write");
        access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 2, "data_read");
        access(1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_C0DE, 3, "inst_read_k3");
        access(1'b1, 1'b0, 32'h0000_0108, 32'h0, 32'h55AA_55AA, 0, "watchdog");
        access(1'b0, 1'b0, 32'h0000_0048, 32'h0, 32'h1111_2222, 1, "after_watchdog");

        // Reset during the second BUSY cycle of a data write.
        @(posedge clk); #1;
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h500; d_wdata = 32'h0000_0001; mem_done = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = d_gnt;
        end
        d_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_busy_gnt: no d_gnt, required d_gnt");
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_busy_outputs: got %h, required 0", outs);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h7777_8888, 1, "after_reset");

        // Spurious done in IDLE, then in RESP.
        mem_done = 1'b1;
        repeat (2) @(negedge clk);
        mem_done = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: mem_valid=%0b i_gnt=%0b d_gnt=%0b, required all 0", mem_valid, i_gnt, d_gnt);
        end
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h9999_AAAA, 1, "spurious_resp");
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        checks++;
        if (mem_valid !== 1'b0 || d_gnt !== 1'b0 || i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL spurious_resp_state: mem_valid=%0b i_gnt=%0b d_gnt=%0b, required all 0", mem_valid, i_gnt, d_gnt);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer in front of the unified cache/RAM memory subsystem. It shares that single memory port between the instruction-fetch side (read-only) and the data side (read/write). It grants one request at a time and holds the address, data and RW stable until the memory side signals completion. It then returns a one-cycle response to the owning requester, and a watchdog counter aborts any access that never completes.

## Interface
- `TIMEOUT`, 255: maximum number of BUSY cycles before the watchdog aborts; legal range 1..255.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: instruction-side read request; held with `i_addr` until `i_gnt`.
- `i_addr` in 32: instruction-side byte address.
- `i_gnt` out 1: one-cycle pulse; instruction request accepted.
- `i_rvalid` out 1: one-cycle pulse; `i_rdata` valid (or aborted, see `err`).
- `i_rdata` out 32: instruction read data.
- `d_req` in 1: data-side request; held with its fields until `d_gnt`.
- `d_rw` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data-side byte address.
- `d_wdata` in 32: data-side write data.
- `d_gnt` out 1: one-cycle pulse; data request accepted.
- `d_rvalid` out 1: one-cycle pulse; completes both reads and writes (write ack).
- `d_rdata` out 32: data read data; 0 for writes.
- `err` out 1: valid with either rvalid; 1 = watchdog abort.
- `mem_address` out 32: address to the memory subsystem.
- `mem_DataIn` out 32: write data to the memory subsystem.
- `mem_RW` out 1: RW to the memory subsystem; forced to 0 for instruction accesses.
- `mem_valid` out 1: access in progress; address, data and RW are stable while high.
- `mem_done` in 1: memory completion; sampled only while `mem_valid` is high.
- `mem_DataR` in 32: memory read data; valid in the cycle `mem_done` is high.

## Operation
- FSM states:
  - IDLE: all strobes low. If any request is present, select a winner, latch its address/data/RW and owner, and go to BUSY.
  - BUSY: `mem_valid` = 1 and the owner's gnt = 1 in the first BUSY cycle only. The watchdog counts from 0.
    - If `mem_done` = 1: capture `mem_DataR` (0 for writes), set `err` = 0, go to RESP.
    - Else if count = `TIMEOUT`-1: set rdata = 0, set `err` = 1, go to RESP.
    - Else: increment the count.
  - RESP: the owner's rvalid = 1 for exactly one cycle, then go to IDLE.
- Requests are not sampled in BUSY or RESP. A requester must hold req until it sees its gnt and drop it (or present a new request) in the cycle after gnt.
- Winner selection when only one request is present: that requester.
- Winner selection when both are present: per Configuration.
- Outputs are registered; no combinational path from any input to any output.
- `mem_done` asserted in IDLE or RESP is ignored.
- The watchdog counter is 8 bits; it is cleared on entry to BUSY and never wraps.

## Timing
- Reset: state = IDLE. All outputs are 0: gnt, rvalid, `err`, `mem_valid`, `mem_RW`, `mem_address`, `mem_DataIn`, rdata. Round-robin pointer = "last served D".
- A reset asserted mid-transaction discards that transaction. No rvalid is issued, and `mem_valid` is 0 in the cycle after the reset edge.
- Request sampled at edge N (IDLE):
  - gnt and `mem_valid` are high in cycle N+1.
  - With `mem_done` already high in N+1: rvalid is high in cycle N+2, and the next request is sampled at edge N+3.
  - Minimum request-to-response latency is therefore 2 cycles, and the maximum issue rate is one access every 3 cycles.
- With `mem_done` first high in the k-th BUSY cycle: rvalid is high in cycle N+1+k.
- Watchdog abort: rvalid with `err` = 1 is high in cycle N+1+`TIMEOUT`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both sides request, the side not served last wins. The pointer updates on every grant, and the first tie after reset goes to I.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority; D always wins ties. There is no pointer register.

## Test plan
- Single read: I reads 0x0000_0040 while `mem_done` is tied to 1 and `mem_DataR` = 0x1234_5678. Required: `i_gnt` at +1, `mem_RW` = 0, `i_rvalid` at +2 with `i_rdata` = 0x1234_5678 and `err` = 0.
- Data write: D writes 0xDEAD_BEEF to 0x100 with `mem_done` delayed 4 BUSY cycles. Required: `mem_valid` high 4 cycles with `mem_address` = 0x100 and `mem_DataIn` = 0xDEAD_BEEF stable; `d_rvalid` at +5 with `d_rdata` = 0.
- Tie:
  - With the macro: both sides request continuously for 4 transactions; grant order I, D, I, D.
  - Without the macro: grant order D, D, D, D.
  - Both: no grant overlaps with `mem_valid` of another access.
- Watchdog: with `TIMEOUT` = 8 and `mem_done` held at 0, a D read gives `d_rvalid` with `err` = 1 and `d_rdata` = 0 at +9; a following I read completes normally.
- Reset in BUSY: assert `rst` in the 2nd BUSY cycle. Required: all outputs 0 next cycle, no rvalid ever issued for that access, and a new I request is served normally.
- Spurious done: `mem_done` pulsed in IDLE and in RESP. Required: no state change and no extra rvalid.
